btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_channel.sv | 123 ++++++++++++
 rtl/btn_debounce.sv | 37 +++
 tb/tb_btn_debounce.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default parameters for the button debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int DEF_N_BTN   = 4;
  localparam int DEF_DEB_CYC = 250000;
  localparam int DEF_REP_EN  = 1;
  localparam int DEF_REP_DLY = 25000000;
  localparam int DEF_REP_PER = 5000000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// pulses and an auto-repeat FSM driving the move pulse.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int REP_EN  = DEF_REP_EN,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls,
  output logic move
);

  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int RMAX = max2(REP_DLY, REP_PER);
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PER - 1);

  logic          sync1, sync2;
  logic [DW-1:0] cnt;
  logic          deb_fire, press_fire, rel_fire, rep_fire;
  rep_state_t    state, state_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Toggle on the edge where the count of differing cycles would hit DEB_CYC.
  assign deb_fire   = (sync2 != level) && (cnt == DEB_LAST);
  assign press_fire = deb_fire & ~level;
  assign rel_fire   = deb_fire & level;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (deb_fire) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt + RW'(1);
    if (rel_fire || (REP_EN == 0)) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          rcnt_nxt = '0;
          if (press_fire) state_nxt = DELAY;
        end
        DELAY: begin
          if (rcnt == DLY_LAST) begin
            state_nxt = REPEAT;
            rcnt_nxt  = '0;
          end
        end
        REPEAT: begin
          if (rcnt == PER_LAST) rcnt_nxt = '0;
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  // A release on the same edge always wins over a due repeat.
  always_comb begin
    rep_fire = 1'b0;
    if (!rel_fire) begin
      if (state == DELAY  && rcnt == DLY_LAST) rep_fire = 1'b1;
      if (state == REPEAT && rcnt == PER_LAST) rep_fire = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      press <= 1'b0;
      rls   <= 1'b0;
      move  <= 1'b0;
    end else begin
      press <= press_fire;
      rls   <= rel_fire;
      move  <= press_fire | rep_fire;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with press/release pulses and auto-repeat.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN   = DEF_N_BTN,
  parameter int DEB_CYC = DEF_DEB_CYC,
  parameter int REP_EN  = DEF_REP_EN,
  parameter int REP_DLY = DEF_REP_DLY,
  parameter int REP_PER = DEF_REP_PER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] move
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEB_CYC(DEB_CYC),
      .REP_EN (REP_EN),
      .REP_DLY(REP_DLY),
      .REP_PER(REP_PER)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rls  (btn_release[i]),
      .move (move[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random button activity,
// compared every cycle against a window-based reference model.
module tb_btn_debounce;

  localparam int NB  = 4;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] lvl_a, prs_a, rel_a, mov_a;
  logic [NB-1:0] lvl_b, prs_b, rel_b, mov_b;

  int errors = 0;
  int checks = 0;

  btn_debounce #(.N_BTN(NB), .DEB_CYC(DEB), .REP_EN(1), .REP_DLY(DLY), .REP_PER(PER)) u_dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .move(mov_a)
  );

  btn_debounce #(.N_BTN(NB), .DEB_CYC(DEB), .REP_EN(0), .REP_DLY(DLY), .REP_PER(PER)) u_dut_norep (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .move(mov_b)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last DEB synchronised samples
  // (raw delayed two edges, all taken since the last reset) differ from it.
  bit [NB-1:0] m_s1, m_s2, m_lvl, e_press, e_rel, e_move;
  bit          m_win[NB][$];
  int          m_ts[NB];

  task automatic model_step(input logic r, input logic [NB-1:0] x);
    bit flip, rep;
    e_press = '0; e_rel = '0; e_move = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int ch = 0; ch < NB; ch++) begin
        m_win[ch].delete();
        m_ts[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < NB; ch++) begin
        m_win[ch].push_back(m_s2[ch]);
        if (m_win[ch].size() > DEB) void'(m_win[ch].pop_front());
        flip = (m_win[ch].size() == DEB);
        for (int k = 0; k < m_win[ch].size(); k++)
          if (m_win[ch][k] == m_lvl[ch]) flip = 1'b0;
        rep = 1'b0;
        if (m_lvl[ch]) begin
          m_ts[ch]++;
          rep = (m_ts[ch] >= DLY) && (((m_ts[ch] - DLY) % PER) == 0);
        end
        if (flip) begin
          if (m_lvl[ch]) begin
            e_rel[ch] = 1'b1;
            rep = 1'b0;
          end else begin
            e_press[ch] = 1'b1;
            m_ts[ch] = 0;
          end
          m_lvl[ch] = ~m_lvl[ch];
        end
        e_move[ch] = e_press[ch] | rep;
      end
      m_s2 = m_s1;
      m_s1 = x;
    end
  endtask

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [NB-1:0] x);
    rst = r;
    btn_raw = x;
    @(posedge clk);
    model_step(r, x);
    #1;
    chk("level", lvl_a, m_lvl);
    chk("press", prs_a, e_press);
    chk("release", rel_a, e_rel);
    chk("move", mov_a, e_move);
    chk("norep_level", lvl_b, m_lvl);
    chk("norep_press", prs_b, e_press);
    chk("norep_release", rel_b, e_rel);
    chk("norep_move", mov_b, e_press);
  endtask

  int          mq0[$];
  int          rq0[$];
  int          exp_mv[4] = '{5, 15, 18, 21};
  int          glitch_seen, seen_all, first, nr_moves;
  int          hold[NB];
  logic [NB-1:0] x, rv;

  initial begin
    tick(1'b1, '0);
    chk("reset_level", lvl_a, '0);
    chk("reset_move", mov_a, '0);
    tick(1'b1, '0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0);

    // Bit0 held then released after the third move; bit1 glitches 3 cycles.
    glitch_seen = 0;
    for (int e = 0; e <= 40; e++) begin
      x = '0;
      x[0] = (e <= 18);
      x[1] = (e >= 2 && e <= 4);
      tick(1'b0, x);
      if (mov_a[0]) mq0.push_back(e);
      if (rel_a[0]) rq0.push_back(e);
      if (prs_a[1] | lvl_a[1] | mov_a[1] | rel_a[1]) glitch_seen++;
    end
    chk_int("move0_count", mq0.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_int("move0_edge", (i < mq0.size()) ? mq0[i] : -1, exp_mv[i]);
    chk_int("release0_count", rq0.size(), 1);
    chk_int("release0_edge", (rq0.size() > 0) ? rq0[0] : -1, 24);
    chk_int("glitch1_activity", glitch_seen, 0);

    // All four channels rise together.
    for (int i = 0; i < 10; i++) tick(1'b0, '0);
    seen_all = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 4'b1111);
      if (prs_a == 4'b1111) seen_all++;
    end
    chk_int("press_all_same_cycle", seen_all, 1);
    for (int i = 0; i < 20; i++) tick(1'b0, '0);

    // Reset while channel 2 sits in the repeat delay.
    for (int i = 0; i < 8; i++) tick(1'b0, 4'b0100);
    tick(1'b1, 4'b0100);
    chk("rst_mid_level", lvl_a, '0);
    chk("rst_mid_press", prs_a, '0);
    chk("rst_mid_move", mov_a, '0);
    first = -1;
    for (int n = 1; n <= 30; n++) begin
      tick(1'b0, 4'b0100);
      if (prs_a[2] && first < 0) first = n;
    end
    chk_int("press2_after_reset", first, DEB + 2);
    for (int i = 0; i < 20; i++) tick(1'b0, '0);

    // Repeat disabled: one long hold gives a single move.
    nr_moves = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 4'b1000);
      if (mov_b[3]) nr_moves++;
    end
    chk_int("norep_move3_count", nr_moves, 1);
    for (int i = 0; i < 20; i++) tick(1'b0, '0);

    // Random levels with random hold times and occasional resets.
    rv = '0;
    for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
    for (int i = 0; i < 500; i++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          rv[ch] = 1'($urandom_range(0, 1));
          hold[ch] = $urandom_range(1, 25);
        end
        hold[ch]--;
      end
      tick(($urandom_range(0, 199) == 0), rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
